// File: rtl/updown_counter_mux_display.sv
// Button-stepped up/down counter with a time-multiplexed hex digit scan.
// Define DEBOUNCE_EN to insert a DEB_CYCLES debounce filter after the synchroniser.
module updown_counter_mux_display #(
  parameter int WIDTH       = 16,
  parameter int DIGITS      = WIDTH / 4,
  parameter int RESET_VAL   = 'h1f,
  parameter int REFRESH_DIV = 1000000,
  parameter int DEB_CYCLES  = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             button,
  input  logic [6:0]       ctrl,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             wrapped,
  output logic [3:0]       result,
  output logic [2:0]       choice
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  if ((WIDTH % 4) != 0 || WIDTH < 4 || WIDTH > 32 ||
      DIGITS < 1 || DIGITS > 8 || DIGITS * 4 > WIDTH ||
      REFRESH_DIV < 1 || DEB_CYCLES < 1) begin : g_bad_param
    $error("updown_counter_mux_display: illegal parameters");
  end

  logic             s1_q, s2_q, prev_q, armed_q;
  logic             armed_d;
  logic [1:0]       vld_q, vld_d;
  logic             lvl, press;
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrapped_q, wrapped_d;
  logic [RW-1:0]    ref_q, ref_d;
  logic [2:0]       choice_q, choice_d;
  logic             tick;
  logic [WIDTH:0]   step_w, sum_w, dif_w;
  logic [WIDTH-1:0] shifted;

`ifdef DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CYCLES + 1);
  logic          deb_q, deb_d;
  logic [DW-1:0] dcnt_q, dcnt_d;

  always_comb begin
    deb_d  = deb_q;
    dcnt_d = '0;
    if (s2_q != deb_q) begin
      if (dcnt_q == DW'(DEB_CYCLES - 1)) begin
        deb_d = s2_q;
      end else begin
        dcnt_d = dcnt_q + DW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      deb_q  <= 1'b0;
      dcnt_q <= '0;
    end else begin
      deb_q  <= deb_d;
      dcnt_q <= dcnt_d;
    end
  end

  assign lvl = deb_q;
`else
  assign lvl = s2_q;
`endif

  // A button held through reset must be seen low once before it may press.
  assign vld_d   = {vld_q[0], 1'b1};
  assign armed_d = armed_q | (vld_q[1] & ~s2_q);
  assign press   = lvl & ~prev_q & armed_q;

  always_comb begin
    step_w    = {{(WIDTH - 3){1'b0}},
                 (ctrl[6:3] == 4'd0) ? 4'd1 : ctrl[6:3]};
    sum_w     = {1'b0, count_q} + step_w;
    dif_w     = {1'b0, count_q} - step_w;
    count_d   = count_q;
    wrapped_d = 1'b0;
    if (press) begin
      if (ctrl[2]) begin
        count_d = load_val;
      end else if (ctrl[0]) begin
        if (sum_w[WIDTH] && ctrl[1]) begin
          count_d = '1;
        end else begin
          count_d   = sum_w[WIDTH-1:0];
          wrapped_d = sum_w[WIDTH];
        end
      end else begin
        if (dif_w[WIDTH] && ctrl[1]) begin
          count_d = '0;
        end else begin
          count_d   = dif_w[WIDTH-1:0];
          wrapped_d = dif_w[WIDTH];
        end
      end
    end
  end

  always_comb begin
    tick     = (ref_q == RW'(REFRESH_DIV - 1));
    ref_d    = tick ? '0 : ref_q + RW'(1);
    choice_d = choice_q;
    if (tick) begin
      choice_d = (choice_q == 3'(DIGITS - 1)) ? 3'd0 : choice_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      prev_q    <= 1'b0;
      armed_q   <= 1'b0;
      vld_q     <= '0;
      count_q   <= WIDTH'(RESET_VAL);
      wrapped_q <= 1'b0;
      ref_q     <= '0;
      choice_q  <= '0;
    end else begin
      s1_q      <= button;
      s2_q      <= s1_q;
      prev_q    <= lvl;
      armed_q   <= armed_d;
      vld_q     <= vld_d;
      count_q   <= count_d;
      wrapped_q <= wrapped_d;
      ref_q     <= ref_d;
      choice_q  <= choice_d;
    end
  end

  assign shifted = count_q >> {choice_q, 2'b00};
  assign result  = shifted[3:0];
  assign count   = count_q;
  assign wrapped = wrapped_q;
  assign choice  = choice_q;

endmodule

// File: tb/tb_updown_counter_mux_display.sv
// Scoreboard bench for updown_counter_mux_display (WIDTH=8, DIGITS=2).
// Build with DEBOUNCE_EN to also exercise the debounce filter.
module tb_updown_counter_mux_display;

`ifdef DEBOUNCE_EN
  localparam int LAT = 11;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       rst, button;
  logic [6:0] ctrl;
  logic [7:0] load_val, count;
  logic       wrapped;
  logic [3:0] result;
  logic [2:0] choice;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] m_count;
  logic [8:0] exp_q[$];

  updown_counter_mux_display #(
    .WIDTH(8), .DIGITS(2), .RESET_VAL('h1f),
    .REFRESH_DIV(4), .DEB_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .button(button),
    .ctrl(ctrl), .load_val(load_val),
    .count(count), .wrapped(wrapped),
    .result(result), .choice(choice)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [6:0] c, input logic [7:0] lv,
                       input int hold, input string tag);
    logic [8:0] s, r, e;
    logic       w;
    s = (c[6:3] == 4'd0) ? 9'd1 : {5'd0, c[6:3]};
    w = 1'b0;
    if (c[2]) begin
      r = {1'b0, lv};
    end else if (c[0]) begin
      r = {1'b0, m_count} + s;
      if (r[8]) begin
        if (c[1]) r = 9'h0ff;
        else w = 1'b1;
      end
    end else begin
      r = {1'b0, m_count} - s;
      if (r[8]) begin
        if (c[1]) r = 9'h000;
        else w = 1'b1;
      end
    end
    exp_q.push_back({w, r[7:0]});
    ctrl = c;
    load_val = lv;
    button = 1'b1;
    step(LAT - 1);
    check({tag, ":pre"}, 32'(count), 32'(m_count));
    step(1);
    e = exp_q.pop_front();
    check({tag, ":cnt"}, 32'(count), 32'(e[7:0]));
    check({tag, ":wrap"}, 32'(wrapped), 32'(e[8]));
    m_count = e[7:0];
    ctrl = ~c;
    load_val = ~lv;
    step(1);
    check({tag, ":wrap_off"}, 32'(wrapped), 32'd0);
    step(hold);
    check({tag, ":held"}, 32'(count), 32'(m_count));
    button = 1'b0;
    step(LAT + 2);
    check({tag, ":idle"}, 32'(count), 32'(m_count));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] prev, ec;
    bit         found;
    rst = 1'b1;
    button = 1'b0;
    ctrl = '0;
    load_val = '0;
    m_count = 8'h1f;
    step(2);
    check("rst:count", 32'(count), 32'h1f);
    check("rst:choice", 32'(choice), 32'd0);
    check("rst:result", 32'(result), 32'hf);
    check("rst:wrapped", 32'(wrapped), 32'd0);
    rst = 1'b0;
    step(5);

    press(7'b0000001, 8'h00, 50, "up1");
    press(7'b0000100, 8'hfe, 0, "ld_fe");
    press(7'b0011001, 8'h00, 0, "wrap_up3");
    press(7'b0000100, 8'hfe, 0, "ld_fe2");
    press(7'b0011011, 8'h00, 0, "sat_up3");
    press(7'b0000100, 8'h00, 0, "ld_00");
    press(7'b0000010, 8'h00, 0, "sat_dn1");
    press(7'b0000000, 8'h00, 0, "wrap_dn1");
    press(7'b1111001, 8'h00, 0, "wrap_up15");
    press(7'b1010010, 8'h00, 0, "sat_dn10");
    press(7'b0000111, 8'h33, 0, "ld_33");
    press(7'b0000100, 8'ha5, 0, "ld_a5");

    prev = choice;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step(1);
      if (choice !== prev) found = 1'b1;
    end
    check("scan:sync", 32'(found), 32'd1);
    ec = prev ^ 3'd1;
    for (int k = 0; k < 16; k++) begin
      check("scan:choice", 32'(choice), 32'(ec));
      check("scan:result", 32'(result),
            32'(ec[0] ? m_count[7:4] : m_count[3:0]));
      step(1);
      if (k % 4 == 3) ec = ec ^ 3'd1;
    end

    ctrl = 7'b0000001;
    button = 1'b1;
    step(1);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    m_count = 8'h1f;
    check("rst_mid:choice", 32'(choice), 32'd0);
    step(LAT + 10);
    check("rst_mid:held", 32'(count), 32'h1f);
    button = 1'b0;
    step(LAT + 2);
    press(7'b0000001, 8'h00, 4, "rst_mid:up1");

`ifdef DEBOUNCE_EN
    for (int g = 0; g < 3; g++) begin
      button = 1'b1;
      step(5);
      button = 1'b0;
      step(12);
      check("deb:glitch", 32'(count), 32'(m_count));
    end
    press(7'b0000001, 8'h00, 8, "deb:up1");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
